// File: rtl/icsp_pkg.sv
// Shared constants and state encoding for the ICSP program loader.
package icsp_pkg;

    localparam int unsigned CMD_BITS        = 6;
    localparam int unsigned DATA_FRAME_BITS = 16;

    localparam logic [CMD_BITS-1:0] CMD_LOAD_DATA  = 6'b000010;
    localparam logic [CMD_BITS-1:0] CMD_INC_ADDR   = 6'b000110;
    localparam logic [CMD_BITS-1:0] CMD_BEGIN_PROG = 6'b001000;
    localparam logic [CMD_BITS-1:0] CMD_RESET_ADDR = 6'b010110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_DATA  = 2'd2,
        S_WRITE = 2'd3
    } icsp_state_t;

endpackage

// File: rtl/icsp_sync_edge.sv
// Two-flop synchronizers for the programmer pins plus a registered
// falling-edge detector on icsp_clk; data is delayed to line up with the edge.
module icsp_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic prog_en,
    input  logic icsp_clk,
    input  logic icsp_data,
    output logic sync_prog_en,
    output logic sync_data,
    output logic clk_fall
);

    logic r_pe_meta;
    logic r_pe_sync;
    logic r_ck_meta;
    logic r_ck_sync;
    logic r_ck_prev;
    logic r_dat_meta;
    logic r_dat_sync;
    logic r_dat_q;
    logic r_fall;

    // Synchronize inputs and register the icsp_clk high-to-low transition
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pe_meta  <= 1'b0;
            r_pe_sync  <= 1'b0;
            r_ck_meta  <= 1'b0;
            r_ck_sync  <= 1'b0;
            r_ck_prev  <= 1'b0;
            r_dat_meta <= 1'b0;
            r_dat_sync <= 1'b0;
            r_dat_q    <= 1'b0;
            r_fall     <= 1'b0;
        end else begin
            r_pe_meta  <= prog_en;
            r_pe_sync  <= r_pe_meta;
            r_ck_meta  <= icsp_clk;
            r_ck_sync  <= r_ck_meta;
            r_ck_prev  <= r_ck_sync;
            r_dat_meta <= icsp_data;
            r_dat_sync <= r_dat_meta;
            r_dat_q    <= r_dat_sync;
            r_fall     <= r_ck_prev & ~r_ck_sync;
        end
    end

    assign sync_prog_en = r_pe_sync;
    assign sync_data    = r_dat_q;
    assign clk_fall     = r_fall;

endmodule

// File: rtl/icsp_program_loader.sv
// Serial ICSP receiver: decodes command/data frames and drives the program
// memory write port while holding the core off.
module icsp_program_loader
    import icsp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 13,
    parameter int unsigned INSTR_WIDTH = 14,
    parameter int unsigned CMD_WIDTH   = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   prog_en,
    input  logic                   icsp_clk,
    input  logic                   icsp_data,
    output logic                   cpu_hold,
    output logic                   mem_wr_en,
    output logic [ADDR_WIDTH-1:0]  mem_wr_addr,
    output logic [INSTR_WIDTH-1:0] mem_wr_data,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(DATA_FRAME_BITS + 1);

    logic w_pe;
    logic w_dat;
    logic w_fall;

    icsp_state_t             r_state;
    logic                    r_pe_q;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_FRAME_BITS-1:0] r_shift;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [INSTR_WIDTH-1:0]  r_data;
    logic                    r_wr_en;
    logic                    r_hold;
    logic                    r_busy;

    icsp_state_t             w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [DATA_FRAME_BITS-1:0] w_shift_nxt;
    logic [ADDR_WIDTH-1:0]   w_addr_nxt;
    logic [INSTR_WIDTH-1:0]  w_data_nxt;
    logic                    w_wr_en_nxt;
    logic                    w_hold_nxt;
    logic                    w_busy_nxt;

    logic [DATA_FRAME_BITS-1:0] w_shift_in;
    logic [CMD_WIDTH-1:0]    w_cmd;

    icsp_sync_edge u_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .prog_en      (prog_en),
        .icsp_clk     (icsp_clk),
        .icsp_data    (icsp_data),
        .sync_prog_en (w_pe),
        .sync_data    (w_dat),
        .clk_fall     (w_fall)
    );

    // Bits arrive LSB first, so shift in at the top; a full frame ends up aligned
    assign w_shift_in = {w_dat, r_shift[DATA_FRAME_BITS-1:1]};
    assign w_cmd      = w_shift_in[DATA_FRAME_BITS-1 -: CMD_WIDTH];

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pe_q  <= 1'b0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_wr_en <= 1'b0;
            r_hold  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pe_q  <= w_pe;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_wr_en <= w_wr_en_nxt;
            r_hold  <= w_hold_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state, frame collection and command decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_wr_en_nxt = 1'b0;
        w_hold_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_pe && !r_pe_q) begin
                    w_state_nxt = S_CMD;
                    w_addr_nxt  = '0;
                    w_cnt_nxt   = '0;
                end
            end
            S_CMD: begin
                if (!w_pe) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_fall) begin
                    w_shift_nxt = w_shift_in;
                    if (r_cnt == CNT_W'(CMD_WIDTH - 1)) begin
                        w_cnt_nxt = '0;
                        case (w_cmd)
                            CMD_LOAD_DATA:  w_state_nxt = S_DATA;
                            CMD_INC_ADDR:   w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
                            CMD_BEGIN_PROG: begin
                                w_state_nxt = S_WRITE;
                                w_wr_en_nxt = 1'b1;
                            end
                            CMD_RESET_ADDR: w_addr_nxt  = '0;
                            default: ;
                        endcase
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (!w_pe) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_fall) begin
                    w_shift_nxt = w_shift_in;
                    if (r_cnt == CNT_W'(DATA_FRAME_BITS - 1)) begin
                        w_cnt_nxt   = '0;
                        w_data_nxt  = w_shift_in[INSTR_WIDTH:1];
                        w_state_nxt = S_CMD;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_WRITE: begin
                w_state_nxt = w_pe ? S_CMD : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        w_hold_nxt = (w_state_nxt != S_IDLE);
        w_busy_nxt = ((w_state_nxt == S_CMD) || (w_state_nxt == S_DATA)) &&
                     (w_cnt_nxt != '0);
    end

    assign cpu_hold    = r_hold;
    assign mem_wr_en   = r_wr_en;
    assign mem_wr_addr = r_addr;
    assign mem_wr_data = r_data;
    assign busy        = r_busy;

endmodule

// File: tb/tb_icsp_program_loader.sv
// Bench for icsp_program_loader: programmer-level model with expected-write
// queues; a second, narrow-address instance shares the inputs to reach wrap.
module tb_icsp_program_loader;
    import icsp_pkg::*;

    localparam int unsigned NARROW_AW = 5;

    logic clk;
    logic rst_n;
    logic prog_en;
    logic icsp_clk;
    logic icsp_data;

    logic        hold_a, wen_a, busy_a;
    logic [12:0] addr_a;
    logic [13:0] data_a;
    logic        hold_b, wen_b, busy_b;
    logic [NARROW_AW-1:0] addr_b;
    logic [13:0] data_b;

    icsp_program_loader dut (
        .clk (clk), .rst_n (rst_n), .prog_en (prog_en),
        .icsp_clk (icsp_clk), .icsp_data (icsp_data),
        .cpu_hold (hold_a), .mem_wr_en (wen_a), .mem_wr_addr (addr_a),
        .mem_wr_data (data_a), .busy (busy_a)
    );

    icsp_program_loader #(.ADDR_WIDTH(NARROW_AW)) dut_n (
        .clk (clk), .rst_n (rst_n), .prog_en (prog_en),
        .icsp_clk (icsp_clk), .icsp_data (icsp_data),
        .cpu_hold (hold_b), .mem_wr_en (wen_b), .mem_wr_addr (addr_b),
        .mem_wr_data (data_b), .busy (busy_b)
    );

    typedef struct {
        int unsigned addr;
        logic [13:0] data;
    } wr_t;

    wr_t         wq_a[$];
    wr_t         wq_b[$];
    int unsigned m_addr = 0;
    logic [13:0] m_data = '0;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;
    bit hold_chk = 0;
    int strobes_a = 0;
    int unsigned last_addr_a = 0;
    logic [13:0] last_data_a = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of strobes and hold against the model
    always @(negedge clk) begin
        if (chk_en) begin
            wr_t w;
            if (wen_a) begin
                strobes_a++;
                last_addr_a = 32'(addr_a);
                last_data_a = data_a;
                check("strobe_a_expected", 32'(wq_a.size() != 0), 32'd1);
                if (wq_a.size() != 0) begin
                    w = wq_a.pop_front();
                    check("wr_addr_a", 32'(addr_a), w.addr % 8192);
                    check("wr_data_a", 32'(data_a), 32'(w.data));
                end
            end
            if (wen_b) begin
                check("strobe_b_expected", 32'(wq_b.size() != 0), 32'd1);
                if (wq_b.size() != 0) begin
                    w = wq_b.pop_front();
                    check("wr_addr_b", 32'(addr_b), w.addr % 32);
                    check("wr_data_b", 32'(data_b), 32'(w.data));
                end
            end
            if (hold_chk) begin
                check("cpu_hold_a", 32'(hold_a), 32'd1);
                check("cpu_hold_b", 32'(hold_b), 32'd1);
            end
            check("busy_without_hold", 32'(busy_a & ~hold_a), 32'd0);
        end
    end

    task automatic send_bits(input logic [15:0] v, input int n, input int half);
        logic [15:0] vv;
        vv = v;
        for (int i = 0; i < n; i++) begin
            icsp_data = vv[i];
            icsp_clk  = 1'b1;
            repeat (half) @(negedge clk);
            icsp_clk  = 1'b0;
            repeat (half) @(negedge clk);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_addr_a"}, 32'(addr_a), m_addr);
        check({tag, "_addr_b"}, 32'(addr_b), m_addr % 32);
        check({tag, "_data_a"}, 32'(data_a), 32'(m_data));
        check({tag, "_data_b"}, 32'(data_b), 32'(m_data));
    endtask

    task automatic do_cmd(input logic [5:0] code, input int half);
        wr_t w;
        case (code)
            CMD_INC_ADDR:   m_addr = (m_addr + 1) % 8192;
            CMD_RESET_ADDR: m_addr = 0;
            CMD_BEGIN_PROG: begin
                w.addr = m_addr;
                w.data = m_data;
                wq_a.push_back(w);
                wq_b.push_back(w);
            end
            default: ;
        endcase
        send_bits({10'd0, code}, 6, half);
        repeat (6) @(negedge clk);
        if (code == CMD_BEGIN_PROG) begin
            check("pending_a", 32'(wq_a.size()), 32'd0);
            check("pending_b", 32'(wq_b.size()), 32'd0);
        end
        if (code != CMD_LOAD_DATA) check_state("after_cmd");
    endtask

    task automatic do_load(input logic [13:0] payload, input int half);
        logic [15:0] frame;
        frame  = {1'($urandom), payload, 1'($urandom)};
        m_data = payload;
        do_cmd(CMD_LOAD_DATA, half);
        send_bits(frame, 16, half);
        repeat (6) @(negedge clk);
        check_state("after_load");
    endtask

    task automatic enter_prog();
        prog_en = 1'b1;
        m_addr  = 0;
        repeat (6) @(negedge clk);
        check("enter_hold", 32'(hold_a), 32'd1);
        check("enter_addr", 32'(addr_a), 32'd0);
        hold_chk = 1;
    endtask

    task automatic leave_prog();
        hold_chk = 0;
        prog_en  = 1'b0;
        repeat (6) @(negedge clk);
        check("leave_hold", 32'(hold_a), 32'd0);
        check("leave_busy", 32'(busy_a), 32'd0);
        check("leave_hold_b", 32'(hold_b), 32'd0);
    endtask

    function automatic logic [5:0] rand_invalid();
        logic [5:0] c;
        do c = 6'($urandom_range(0, 63));
        while (c == CMD_LOAD_DATA || c == CMD_INC_ADDR ||
               c == CMD_BEGIN_PROG || c == CMD_RESET_ADDR);
        return c;
    endfunction

    initial begin
        int s0;
        rst_n = 1'b0; prog_en = 1'b0; icsp_clk = 1'b0; icsp_data = 1'b0;

        // Reset with toggling inputs
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            prog_en = 1'($urandom); icsp_clk = 1'($urandom); icsp_data = 1'($urandom);
        end
        check("rst_hold", 32'(hold_a), 32'd0);
        check("rst_wen", 32'(wen_a), 32'd0);
        check("rst_addr", 32'(addr_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        prog_en = 1'b0; icsp_clk = 1'b0; icsp_data = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_hold", 32'(hold_a), 32'd0);
        chk_en = 1;

        // Single write
        enter_prog();
        do_load(14'h30AB, 4);
        do_cmd(CMD_BEGIN_PROG, 4);
        check("single_strobes", 32'(strobes_a), 32'd1);
        check("single_addr", last_addr_a, 32'd0);
        check("single_data", 32'(last_data_a), 32'h30AB);

        // Address sequence
        do_load(14'h0001, 4);
        do_cmd(CMD_BEGIN_PROG, 4);
        do_cmd(CMD_INC_ADDR, 4);
        do_load(14'h0002, 5);
        do_cmd(CMD_BEGIN_PROG, 5);
        check("seq_strobes", 32'(strobes_a), 32'd3);
        check("seq_addr", last_addr_a, 32'd1);
        check("seq_data", 32'(last_data_a), 32'h0002);

        // Invalid command: no strobe, nothing changes
        s0 = strobes_a;
        do_cmd(6'b111111, 4);
        check("invalid_no_strobe", 32'(strobes_a), 32'(s0));

        // Wrap on the narrow instance, then Reset Address
        do_cmd(CMD_RESET_ADDR, 4);
        for (int i = 0; i < 31; i++) do_cmd(CMD_INC_ADDR, 4);
        check("wrap_top", 32'(addr_b), 32'd31);
        do_cmd(CMD_INC_ADDR, 4);
        check("wrap_zero_b", 32'(addr_b), 32'd0);
        check("wrap_wide_a", 32'(addr_a), 32'd32);
        do_load(14'h0DEF, 4);
        do_cmd(CMD_BEGIN_PROG, 4);
        do_cmd(CMD_RESET_ADDR, 4);
        check("reset_addr_a", 32'(addr_a), 32'd0);

        // Slow and fast icsp_clk give the same write
        s0 = strobes_a;
        do_load(14'h2A5C, 50);
        do_cmd(CMD_BEGIN_PROG, 50);
        check("slow_data", 32'(last_data_a), 32'h2A5C);
        do_load(14'h1111, 4);
        do_load(14'h2A5C, 4);
        do_cmd(CMD_BEGIN_PROG, 4);
        check("fast_data", 32'(last_data_a), 32'h2A5C);
        check("ratio_strobes", 32'(strobes_a - s0), 32'd2);

        // Abort mid data frame
        do_load(14'h1555, 4);
        do_cmd(CMD_LOAD_DATA, 4);
        send_bits(16'hFFFF, 8, 4);
        repeat (2) @(negedge clk);
        check("abort_busy", 32'(busy_a), 32'd1);
        leave_prog();
        check("abort_data", 32'(data_a), 32'h1555);
        // Edges while idle are ignored
        send_bits(16'h0008, 6, 4);
        repeat (4) @(negedge clk);
        check("idle_edges_busy", 32'(busy_a), 32'd0);
        enter_prog();
        do_cmd(CMD_BEGIN_PROG, 4);
        check("abort_rewrite", 32'(last_data_a), 32'h1555);

        // Randomized command stream
        for (int k = 0; k < 80; k++) begin
            int half;
            int op;
            half = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 50))
                                                : int'($urandom_range(4, 8));
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2: do_load(14'($urandom), half);
                3, 4:    do_cmd(CMD_BEGIN_PROG, half);
                5, 6:    do_cmd(CMD_INC_ADDR, half);
                7:       do_cmd(CMD_RESET_ADDR, half);
                8:       do_cmd(rand_invalid(), half);
                default: begin
                    leave_prog();
                    enter_prog();
                end
            endcase
        end

        leave_prog();
        check("final_pending_a", 32'(wq_a.size()), 32'd0);
        check("final_pending_b", 32'(wq_b.size()), 32'd0);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/icsp_program_loader.md
Name: icsp_program_loader

Overview:
- Serial in-circuit programming receiver. It writes the 14-bit program memory from an external programmer while the core is held off.
- Accepts a PIC-style two-wire bitstream (icsp_clk, icsp_data) and decodes 6-bit commands plus 16-bit data frames.
- Drives the program memory write port: address, data and a one-cycle write strobe. Asserts cpu_hold so the fetch stage stays flushed during programming.

Parameters:
- ADDR_WIDTH, 13, program memory address width; the address counter wraps at 2**ADDR_WIDTH.
- INSTR_WIDTH, 14, instruction word width; the data frame carries INSTR_WIDTH payload bits.
- CMD_WIDTH, 6, command frame length in bits.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- prog_en  in  1  programming-mode request, asynchronous to clk.
- icsp_clk  in  1  programmer serial clock, asynchronous to clk.
- icsp_data  in  1  programmer serial data, asynchronous to clk.
- cpu_hold  out  1  high while in programming mode; drives the core's rst/flush.
- mem_wr_en  out  1  one-cycle write strobe to program memory.
- mem_wr_addr  out  ADDR_WIDTH  current program address.
- mem_wr_data  out  INSTR_WIDTH  latched instruction word.
- busy  out  1  high while a frame is being shifted in.

Behaviour:
- Reset (rst_n low at posedge): state IDLE, cpu_hold=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, busy=0, shift count=0. Reset wins over every other event.
- Input sync: prog_en, icsp_clk and icsp_data each pass through 2 flops.
- Edge detect: falling edge of synced icsp_clk is registered. Bits are sampled from synced icsp_data on that edge, LSB first.
- Timing requirement on the programmer: each icsp_clk level lasts at least 4 clk cycles.
- FSM states: IDLE, CMD, DATA, WRITE.
- IDLE:
  - cpu_hold=0.
  - Synced prog_en rising -> CMD, mem_wr_addr cleared to 0, cpu_hold=1 from the next cycle.
- CMD (collects CMD_WIDTH bits):
  - busy=1 from the first bit until the last bit.
  - On the 6th bit the command is decoded:
    - 6'b000010 Load Data -> DATA.
    - 6'b000110 Increment Address -> mem_wr_addr+1, wraps 2**ADDR_WIDTH-1 -> 0; stay in CMD.
    - 6'b001000 Begin Programming -> WRITE.
    - 6'b010110 Reset Address -> mem_wr_addr=0; stay in CMD.
    - Any other code is ignored; stay in CMD with no side effects.
- DATA (collects 16 bits):
  - Frame layout: start bit, 14 payload bits, stop bit.
  - After the 16th bit, mem_wr_data takes bits [14:1] of the frame; start and stop bits are ignored. Return to CMD.
- WRITE:
  - mem_wr_en=1 for exactly one clk cycle, with the current addr and data. Next cycle returns to CMD.
  - Latency: strobe in the cycle after the registered edge that completed the Begin Programming command.
  - The address does not auto-increment.
  - Begin Programming with no prior Load Data writes the current latch (0 after reset).
- Leaving programming mode: synced prog_en low in any non-IDLE state -> IDLE at the next posedge.
  - Any partial frame is discarded and the shift count is cleared.
  - A pending WRITE still completes its single strobe, then goes to IDLE.
  - cpu_hold drops on entry to IDLE.
- Falling edges while in IDLE are ignored.
- mem_wr_data and mem_wr_addr hold their values between writes.

Decomposition:
- Shared package icsp_pkg holds:
  - command localparams: CMD_LOAD_DATA, CMD_INC_ADDR, CMD_BEGIN_PROG, CMD_RESET_ADDR;
  - the state encoding;
  - DATA_FRAME_BITS=16.
- Natural sub-module: icsp_sync_edge. It contains the 2-flop synchronizers for the three inputs plus the registered falling-edge detector on icsp_clk, and outputs sync_prog_en, sync_data and clk_fall.
- The program memory gains a write port (wr_en, wr_addr, wr_data) fed directly by this block.

Test Plan:
- Reset: hold rst_n low with toggling inputs -> all outputs 0, state IDLE; release with prog_en=0 -> cpu_hold stays 0.
- Single write:
  - Stimulus: prog_en=1, Load Data with payload 14'h30AB, then Begin Programming.
  - Required: exactly one mem_wr_en pulse with addr=0 and data=14'h30AB, and cpu_hold=1 throughout.
- Address sequence:
  - Stimulus: Load 14'h0001, Begin, Increment, Load 14'h0002, Begin.
  - Required: writes at addr 0 and 1 with the correct data.
- Wrap and reset address:
  - Stimulus: 8191 Increments, then 1 Increment, then Reset Address.
  - Required: addr goes 8191 -> 0; Reset Address forces 0.
- Invalid command and abort:
  - Stimulus: command 6'b111111.
  - Required: no strobe; addr and data unchanged.
  - Stimulus: drop prog_en after 8 data bits.
  - Required: IDLE, cpu_hold=0, mem_wr_data unchanged.
- Slow/fast clock ratio:
  - Stimulus: icsp_clk half-period of 4 clk cycles and of 50 clk cycles.
  - Required: identical write results; exactly one strobe per Begin Programming.
